// File: rtl/ysyx_23060184_ifu_if.sv
// Bundles the IFU's instruction-memory channel and its decode-side handshake.
// The master modport is the IFU's view of these signals; slave is the memory/decode side.
interface ysyx_23060184_ifu_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] ifu_araddr;
    logic                  ifu_arvalid;
    logic                  ifu_arready;
    logic [DATA_WIDTH-1:0] ifu_rdata;
    logic                  ifu_rvalid;
    logic                  ifu_rready;
    logic [DATA_WIDTH-1:0] Inst;
    logic [DATA_WIDTH-1:0] Pc;
    logic                  InstValid;
    logic                  InstReady;
    logic                  Redirect;
    logic [DATA_WIDTH-1:0] RedirectPc;

    modport master (
        output ifu_araddr, ifu_arvalid, ifu_rready, Inst, Pc, InstValid,
        input  ifu_arready, ifu_rdata, ifu_rvalid, InstReady, Redirect, RedirectPc
    );

    modport slave (
        input  ifu_araddr, ifu_arvalid, ifu_rready, Inst, Pc, InstValid,
        output ifu_arready, ifu_rdata, ifu_rvalid, InstReady, Redirect, RedirectPc
    );
endinterface

// File: rtl/ysyx_23060184_ifu.sv
// Non-pipelined instruction fetch unit: one outstanding fetch, PC ownership,
// and redirect handling that kills any in-flight response.
module ysyx_23060184_ifu #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
    input logic                       clk,
    input logic                       rstn,
    ysyx_23060184_ifu_if.master       bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [DATA_WIDTH-1:0] pc_r;
    logic [DATA_WIDTH-1:0] pc_s;
    logic [DATA_WIDTH-1:0] inst_r;
    logic [DATA_WIDTH-1:0] inst_s;
    logic [DATA_WIDTH-1:0] pc_q_r;
    logic [DATA_WIDTH-1:0] pc_q_s;
    logic                  kill_r;
    logic                  kill_s;

    // Outputs depend only on registered state, never on inputs
    assign bus.ifu_arvalid = (state_r == S_REQ);
    assign bus.ifu_rready  = (state_r == S_WAIT);
    assign bus.InstValid   = (state_r == S_OUT);
    assign bus.ifu_araddr  = pc_r;
    assign bus.Inst        = inst_r;
    assign bus.Pc          = pc_q_r;

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= S_IDLE;
            pc_r    <= RESET_PC;
            inst_r  <= '0;
            pc_q_r  <= '0;
            kill_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            inst_r  <= inst_s;
            pc_q_r  <= pc_q_s;
            kill_r  <= kill_s;
        end
    end

    // Next-state and datapath update logic
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        inst_s  = inst_r;
        pc_q_s  = pc_q_r;
        kill_s  = kill_r;
        case (state_r)
            S_IDLE: begin
                state_s = S_REQ;
            end
            S_REQ: begin
                if (bus.ifu_arready) begin
                    state_s = S_WAIT;
                    if (bus.Redirect) begin
                        // The accepted request is already stale; its response must be dropped
                        pc_s   = bus.RedirectPc;
                        kill_s = 1'b1;
                    end else begin
                        pc_s = pc_r;
                    end
                end else if (bus.Redirect) begin
                    pc_s = bus.RedirectPc;
                end else begin
                    pc_s = pc_r;
                end
            end
            S_WAIT: begin
                if (bus.Redirect) begin
                    pc_s   = bus.RedirectPc;
                    kill_s = 1'b1;
                end else begin
                    pc_s = pc_r;
                end
                if (bus.ifu_rvalid) begin
                    if (kill_r || bus.Redirect) begin
                        kill_s  = 1'b0;
                        state_s = S_REQ;
                    end else begin
                        inst_s  = bus.ifu_rdata;
                        pc_q_s  = pc_r;
                        state_s = S_OUT;
                    end
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_OUT: begin
                if (bus.Redirect) begin
                    pc_s    = bus.RedirectPc;
                    state_s = S_REQ;
                end else if (bus.InstReady) begin
                    pc_s    = pc_r + DATA_WIDTH'(4);
                    state_s = S_REQ;
                end else begin
                    state_s = S_OUT;
                end
            end
            default: begin
                state_s = S_IDLE;
                kill_s  = 1'b0;
            end
        endcase
    end
endmodule

// File: doc/ysyx_23060184_ifu.md
# ysyx_23060184_ifu

Instruction fetch unit: owns the program counter, issues one read per instruction to the instruction memory over a valid/ready address and data channel pair, and presents the fetched word with its PC to decode, where the immediate extender consumes it. It is non-pipelined: at most one fetch is outstanding. Redirects from execute (branches, jumps, traps) replace the PC and kill any in-flight fetch.

## Interface
- DATA_WIDTH, 32, width of PC, address and instruction
- RESET_PC, 32'h8000_0000, first fetch address after reset

- clk  in  1  clock, all state updates on rising edge
- rstn  in  1  asynchronous active-low reset
- ifu_araddr  out  DATA_WIDTH  fetch address, equals PC register
- ifu_arvalid  out  1  address request valid
- ifu_arready  in  1  memory accepts address
- ifu_rdata  in  DATA_WIDTH  returned instruction word
- ifu_rvalid  in  1  returned data valid
- ifu_rready  out  1  IFU accepts returned data
- Inst  out  DATA_WIDTH  fetched instruction to decode
- Pc  out  DATA_WIDTH  address of Inst
- InstValid  out  1  Inst/Pc valid for decode
- InstReady  in  1  decode consumes Inst this cycle
- Redirect  in  1  PC redirect request, single-cycle pulse
- RedirectPc  in  DATA_WIDTH  new PC when Redirect=1

## Operation
- States: IDLE, REQ, WAIT, OUT. Registers: state, pc, inst_q, pc_q, kill.
- Reset (rstn=0, asynchronous): state=IDLE, pc=RESET_PC, inst_q=0, pc_q=0, kill=0. All outputs 0 except ifu_araddr=RESET_PC.
- Outputs decoded from state: ifu_arvalid=(REQ), ifu_rready=(WAIT), InstValid=(OUT); ifu_araddr=pc; Inst=inst_q; Pc=pc_q.
- IDLE: unconditionally -> REQ next cycle.
- REQ: arvalid&&arready -> WAIT. Redirect without handshake: pc<=RedirectPc, stay REQ (araddr changes next cycle; instruction memory tolerates address change on an unaccepted request). Redirect with handshake: pc<=RedirectPc, kill<=1, -> WAIT.
- WAIT: Redirect: pc<=RedirectPc, kill<=1. On rvalid: if kill or Redirect this cycle, discard data, kill<=0, -> REQ; else inst_q<=rdata, pc_q<=pc, -> OUT.
- OUT: Inst held stable while InstReady=0. Redirect (priority over InstReady): pc<=RedirectPc, -> REQ, instruction dropped. Else InstReady: pc<=pc+4, -> REQ.
- Arithmetic: pc+4 modulo 2^DATA_WIDTH, wrap 32'hFFFF_FFFC -> 0. RedirectPc taken verbatim; no alignment check.
- kill only set in WAIT or on REQ handshake; cleared exactly when the killed response returns.

## Timing
- Reset release at edge 0: IDLE; edge 1: REQ (arvalid=1).
- Zero-wait memory (arready=1 in REQ, rvalid=1 first WAIT cycle): REQ 1 cycle, WAIT 1 cycle, OUT from third cycle. Fetch-to-decode latency 2 cycles after arvalid rises.
- Throughput with InstReady=1 and zero-wait memory: one instruction per 3 cycles.
- Redirect latency: new PC on ifu_araddr in the cycle after Redirect when landing in REQ; after killed response when Redirect hits WAIT.
- Redirect and rvalid same cycle in WAIT: data discarded, REQ next with RedirectPc.
- Reset mid-fetch: state, kill cleared immediately; a late rvalid after reset is ignored (rready=0 in IDLE/REQ).
- No combinational path from InstReady, Redirect or memory inputs to any output.

## Test plan
- Reset then zero-wait memory returning 32'h0010_0093: arvalid at cycle 1 with araddr 8000_0000, InstValid at cycle 3 with Inst=0010_0093, Pc=8000_0000; InstReady=1 -> next araddr 8000_0004.
- Back-pressure: InstReady=0 for 5 cycles in OUT -> Inst/Pc stable, arvalid=0, pc unchanged; release -> araddr advances by 4.
- Redirect in WAIT with RedirectPc=8000_0100, rvalid 3 cycles later with 32'hDEAD_BEEF -> data dropped, InstValid never 1 for it, next araddr 8000_0100.
- Redirect same cycle as InstReady in OUT -> next araddr=RedirectPc, not pc+4.
- Wrap: RedirectPc=FFFF_FFFC, fetch and consume -> next araddr 0000_0000.
- rstn asserted mid-WAIT, deasserted 2 cycles later -> outputs 0 immediately, fetch restarts at 8000_0000, stale rvalid ignored.
